// File: rtl/spram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spram_arbiter_pkg
// Description : Shared encodings for the single-port weight RAM arbiter:
//               per-cycle bus operations and sequencer states.
// Revision    : 1.0  initial release
// ============================================================================
package spram_arbiter_pkg;

    // Bus operation issued to the SPRAM in a given cycle.
    //   NOP  : RAM deselected
    //   RD   : read at the burst pointer
    //   HOLD : re-present the previous read address so ram_dout stays enabled
    //   WR   : write the requester's word
    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_RD   = 2'd1,
        OP_HOLD = 2'd2,
        OP_WR   = 2'd3
    } op_e;

    // Sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // True for the operations that keep the RAM output enabled.
    function automatic logic op_reads(input op_e op);
        return (op == OP_RD) || (op == OP_HOLD);
    endfunction

endpackage : spram_arbiter_pkg
`default_nettype wire

// File: rtl/spram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : spram_arbiter_if
// Description : Bundle of the requester handshakes and the SPRAM pins around
//               the arbiter. The slave modport is the arbiter; the master
//               modport is its environment (weight loader, MAC burst reader
//               and the SPRAM instance).
// Revision    : 1.0  initial release
// ============================================================================
interface spram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    // Word-write requester
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    // Burst reader
    logic                  rd_start;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [LEN_WIDTH-1:0]  rd_len;
    logic                  rd_busy;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_done;

    // SPRAM pins
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_start, rd_base, rd_len,
        output rd_busy, rd_data, rd_valid, rd_done,
        output ram_cs, ram_we, ram_oe, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_start, rd_base, rd_len,
        input  rd_busy, rd_data, rd_valid, rd_done,
        input  ram_cs, ram_we, ram_oe, ram_addr, ram_din,
        output ram_dout
    );

endinterface : spram_arbiter_if
`default_nettype wire

// File: rtl/spram_burst_cnt.sv
`default_nettype none
// ============================================================================
// Module      : spram_burst_cnt
// Description : Burst address pointer and remaining-word counter. Loaded with
//               base/length at burst start, stepped once per issued read.
//               The pointer wraps modulo the RAM depth.
// Revision    : 1.0  initial release
// ============================================================================
module spram_burst_cnt #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  more,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  C_LEN_ONE = LEN_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    // Load has priority; a step with nothing remaining is ignored.
    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        if (load) begin
            ptr_d = base;
            rem_d = len;
        end else if (step && (rem_q != '0)) begin
            ptr_d = ptr_q + C_PTR_ONE;
            rem_d = rem_q - C_LEN_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end

    assign ptr  = ptr_q;
    assign more = (rem_q != '0);
    assign last = (rem_q == C_LEN_ONE);

endmodule : spram_burst_cnt
`default_nettype wire

// File: rtl/spram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spram_arbiter
// Description : Sequencer/arbiter sharing one single-port weight RAM between
//               a word-write requester and a burst reader. Issues one bus
//               operation per cycle and guarantees that every read is
//               followed by a read or a hold, so the gated RAM output is
//               still enabled in the cycle its data is consumed.
// Revision    : 1.0  initial release
// ============================================================================
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spram_arbiter_if.slave bus
);

    state_e                state_q, state_d;
    op_e                   prev_op_q;
    op_e                   w_op;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;

    logic                  w_cnt_load;
    logic                  w_cnt_step;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic                  w_more;
    logic                  w_last;

    logic                  w_ram_cs;
    logic                  w_ram_we;
    logic                  w_ram_oe;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_din;

    spram_burst_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_burst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_cnt_load),
        .base  (bus.rd_base),
        .len   (bus.rd_len),
        .step  (w_cnt_step),
        .ptr   (w_ptr),
        .more  (w_more),
        .last  (w_last)
    );

    // Per-cycle operation choice and next state. Inside a burst, a read is
    // always followed by a read or hold; otherwise a waiting write gets one
    // slot before the next read, giving the RD,HOLD,WR rotation under load.
    always_comb begin
        w_op       = OP_NOP;
        state_d    = state_q;
        done_d     = 1'b0;
        w_cnt_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.wr_valid) begin
                    w_op = OP_WR;
                end
                if (bus.rd_start) begin
                    w_cnt_load = 1'b1;
                    state_d    = ST_BURST;
                    // Zero-length burst completes in its first busy cycle.
                    done_d     = (bus.rd_len == '0);
                end
            end
            ST_BURST: begin
                if (prev_op_q == OP_RD) begin
                    w_op = (w_more && !bus.wr_valid) ? OP_RD : OP_HOLD;
                end else if (bus.wr_valid && (prev_op_q != OP_WR)) begin
                    w_op = OP_WR;
                end else if (w_more) begin
                    w_op = OP_RD;
                end else if (bus.wr_valid) begin
                    w_op = OP_WR;
                end
                // Done is flagged one cycle after the last read, together
                // with that word's rd_valid.
                if ((w_op == OP_RD) && w_last) begin
                    done_d = 1'b1;
                end
                if (done_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_cnt_step  = (w_op == OP_RD);
    assign hold_addr_d = (w_op == OP_RD) ? w_ptr : hold_addr_q;

    // Sequencer registers: state, last issued op, done pulse, hold address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prev_op_q   <= OP_NOP;
            done_q      <= 1'b0;
            hold_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_op_q   <= w_op;
            done_q      <= done_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    // RAM pin decode; everything is forced low while reset is asserted so
    // the RAM is deselected immediately rather than at the next edge.
    always_comb begin
        w_ram_cs   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_oe   = 1'b0;
        w_ram_addr = '0;
        w_ram_din  = '0;
        if (rst_n) begin
            w_ram_oe = op_reads(w_op);
            unique case (w_op)
                OP_RD: begin
                    w_ram_cs   = 1'b1;
                    w_ram_addr = w_ptr;
                end
                OP_HOLD: begin
                    w_ram_cs   = 1'b1;
                    w_ram_addr = hold_addr_q;
                end
                OP_WR: begin
                    w_ram_cs   = 1'b1;
                    w_ram_we   = 1'b1;
                    w_ram_addr = bus.wr_addr;
                    w_ram_din  = bus.wr_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ram_cs   = w_ram_cs;
    assign bus.ram_we   = w_ram_we;
    assign bus.ram_oe   = w_ram_oe;
    assign bus.ram_addr = w_ram_addr;
    assign bus.ram_din  = w_ram_din;

    assign bus.wr_ready = rst_n && (w_op == OP_WR);
    assign bus.rd_valid = (prev_op_q == OP_RD);
    assign bus.rd_busy  = (state_q == ST_BURST);
    assign bus.rd_done  = done_q;
    assign bus.rd_data  = bus.ram_dout;

endmodule : spram_arbiter
`default_nettype wire
